// File: rtl/flappy_game_controller_if.sv
// flappy_game_controller_if: player, frame and geometry inputs plus the game control outputs
interface flappy_game_controller_if #(
    parameter int XW = 11
);
    logic          key_n;
    logic          frame_tick;
    logic          collision;
    logic [XW-1:0] bird_x;
    logic [XW-1:0] pipe1_x;
    logic [XW-1:0] pipe2_x;
    logic [2:0]    state;
    logic          restart;
    logic          run_en;
    logic          fall_en;
    logic          flap_pulse;
    logic          score_inc;
    logic          gameover;

    modport master (
        output key_n, frame_tick, collision, bird_x, pipe1_x, pipe2_x,
        input  state, restart, run_en, fall_en, flap_pulse, score_inc, gameover
    );

    modport slave (
        input  key_n, frame_tick, collision, bird_x, pipe1_x, pipe2_x,
        output state, restart, run_en, fall_en, flap_pulse, score_inc, gameover
    );
endinterface

// File: rtl/flappy_game_controller.sv
// flappy_game_controller: game state machine, key synchroniser and pipe-pass scoring
module flappy_game_controller #(
    parameter int READY_FRAMES = 30,
    parameter int DEATH_FRAMES = 60,
    parameter int XW           = 11
) (
    input logic                     clock,
    input logic                     reset,
    flappy_game_controller_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READY = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_DYING = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;
    localparam logic [7:0] READY_LAST = 8'(READY_FRAMES - 1);
    localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);

    logic          r_sync1, r_sync2, r_key_prev, r_key_edge;
    logic          r_tick, r_coll;
    logic [XW-1:0] r_bird, r_p1, r_p2, r_prev1, r_prev2;
    logic [2:0]    r_state;
    logic [7:0]    r_cnt;
    logic          r_restart, r_run_en, r_fall_en, r_flap, r_score, r_pending, r_gameover;
    logic [2:0]    w_next;
    logic          w_restart, w_pass1, w_pass2, w_stay_play;
    logic [1:0]    w_events;

    // Next state; key edges only matter in IDLE and OVER, collision only in PLAY
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = r_key_edge ? S_READY : S_IDLE;
            S_READY: w_next = (r_tick && r_cnt == READY_LAST) ? S_PLAY : S_READY;
            S_PLAY:  w_next = r_coll ? S_DYING : S_PLAY;
            S_DYING: w_next = (r_tick && r_cnt == DEATH_LAST) ? S_OVER : S_DYING;
            S_OVER:  w_next = r_key_edge ? S_READY : S_OVER;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_restart   = (r_state == S_IDLE || r_state == S_OVER) && r_key_edge;
    assign w_pass1     = r_tick && (r_prev1 > r_bird) && (r_p1 <= r_bird);
    assign w_pass2     = r_tick && (r_prev2 > r_bird) && (r_p2 <= r_bird);
    assign w_events    = 2'(w_pass1) + 2'(w_pass2) + 2'(r_pending);
    assign w_stay_play = (r_state == S_PLAY) && (w_next == S_PLAY);

    // Two-flop synchroniser storing the pressed level, then a registered rising-edge detect
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_key_prev <= 1'b0;
            r_key_edge <= 1'b0;
        end else begin
            r_sync1    <= ~bus.key_n;
            r_sync2    <= r_sync1;
            r_key_prev <= r_sync2;
            r_key_edge <= r_sync2 & ~r_key_prev;
        end
    end

    // Register frame, collision and geometry together so pass checks see aligned values
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tick <= 1'b0;
            r_coll <= 1'b0;
            r_bird <= '0;
            r_p1   <= '0;
            r_p2   <= '0;
        end else begin
            r_tick <= bus.frame_tick;
            r_coll <= bus.collision;
            r_bird <= bus.bird_x;
            r_p1   <= bus.pipe1_x;
            r_p2   <= bus.pipe2_x;
        end
    end

    // State register and frame counter, cleared on every state change
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 8'd0 : r_tick ? r_cnt + 8'd1 : r_cnt;
        end
    end

    // Previous pipe positions; restart zeroes them so the first PLAY tick cannot score
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev1 <= '0;
            r_prev2 <= '0;
        end else begin
            r_prev1 <= w_restart ? '0 : r_tick ? r_p1 : r_prev1;
            r_prev2 <= w_restart ? '0 : r_tick ? r_p2 : r_prev2;
        end
    end

    // Registered control outputs derived from the next state; a double pass defers one increment
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_restart  <= 1'b0;
            r_run_en   <= 1'b0;
            r_fall_en  <= 1'b0;
            r_gameover <= 1'b0;
            r_flap     <= 1'b0;
            r_score    <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            r_restart  <= w_restart;
            r_run_en   <= w_next == S_PLAY;
            r_fall_en  <= w_next == S_PLAY || w_next == S_DYING;
            r_gameover <= w_next == S_DYING || w_next == S_OVER;
            r_flap     <= (r_state == S_PLAY) && r_key_edge;
            r_score    <= w_stay_play && (w_events != 2'd0);
            r_pending  <= w_stay_play && w_events[1];
        end
    end

    assign bus.state      = r_state;
    assign bus.restart    = r_restart;
    assign bus.run_en     = r_run_en;
    assign bus.fall_en    = r_fall_en;
    assign bus.gameover   = r_gameover;
    assign bus.flap_pulse = r_flap;
    assign bus.score_inc  = r_score;
endmodule

// File: tb/tb_flappy_game_controller.sv
// tb_flappy_game_controller: directed scenario bench for the game controller
module tb_flappy_game_controller;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    flappy_game_controller_if #(.XW(11)) bus ();

    flappy_game_controller #(.READY_FRAMES(30), .DEATH_FRAMES(60), .XW(11)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        tick();
        bus.frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] v;
        repeat (3) tick();
        v = {bus.state, bus.restart, bus.run_en, bus.fall_en, bus.flap_pulse, bus.score_inc, bus.gameover};
        checks++;
        if (v !== 9'd0) begin errors++; $display("FAIL reset_held outputs=%b want 0", v); end
        reset = 1'b1;
        repeat (2) tick();
        v = {bus.state, bus.restart, bus.run_en, bus.fall_en, bus.flap_pulse, bus.score_inc, bus.gameover};
        checks++;
        if (v !== 9'd0) begin errors++; $display("FAIL reset_release outputs=%b want 0", v); end
    endtask

    task automatic test_start();
        int first = 0, cnt = 0;
        bus.key_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.restart) begin cnt++; if (first == 0) first = i; end
        end
        bus.key_n = 1'b1;
        checks++;
        if (first !== 4 || cnt !== 1) begin errors++; $display("FAIL start_restart first=%0d count=%0d want 4/1", first, cnt); end
        checks++;
        if (bus.state !== 3'd1) begin errors++; $display("FAIL start_state got %0d want 1", bus.state); end
        repeat (3) tick();
        cnt = 0;
        bus.key_n = 1'b0;
        for (int i = 1; i <= 6; i++) begin tick(); if (bus.restart) cnt++; end
        bus.key_n = 1'b1;
        checks++;
        if (cnt !== 0 || bus.state !== 3'd1) begin errors++; $display("FAIL ready_key_ignored restarts=%0d state=%0d want 0/1", cnt, bus.state); end
        repeat (3) tick();
        repeat (29) frame();
        tick();
        checks++;
        if (bus.state !== 3'd1) begin errors++; $display("FAIL ready_29 state=%0d want 1", bus.state); end
        frame();
        tick();
        checks++;
        if ({bus.state, bus.run_en, bus.fall_en, bus.gameover} !== {3'd2, 3'b110}) begin
            errors++; $display("FAIL play_entry state=%0d run=%b fall=%b go=%b want 2/1/1/0", bus.state, bus.run_en, bus.fall_en, bus.gameover);
        end
    endtask

    task automatic test_flap();
        int first = 0, cnt = 0;
        bus.key_n = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.flap_pulse) begin cnt++; if (first == 0) first = i; end
        end
        bus.key_n = 1'b1;
        checks++;
        if (first !== 4 || cnt !== 1) begin errors++; $display("FAIL flap_hold first=%0d count=%0d want 4/1", first, cnt); end
        repeat (4) tick();
        first = 0; cnt = 0;
        bus.key_n = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (bus.flap_pulse) begin cnt++; if (first == 0) first = i; end
        end
        bus.key_n = 1'b1;
        checks++;
        if (first !== 4 || cnt !== 1) begin errors++; $display("FAIL flap_repress first=%0d count=%0d want 4/1", first, cnt); end
        repeat (4) tick();
    endtask

    task automatic test_score();
        int first = 0, cnt = 0;
        bus.pipe1_x = 11'd102;
        frame();
        repeat (2) tick();
        bus.pipe1_x = 11'd99;
        frame();
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (bus.score_inc) begin cnt++; if (first == 0) first = i; end
        end
        checks++;
        if (first !== 1 || cnt !== 1) begin errors++; $display("FAIL score_pass first=%0d count=%0d want 1/1", first, cnt); end
        cnt = 0;
        bus.pipe1_x = 11'd5;
        frame();
        for (int i = 0; i < 3; i++) begin tick(); if (bus.score_inc) cnt++; end
        bus.pipe1_x = 11'd600;
        frame();
        for (int i = 0; i < 3; i++) begin tick(); if (bus.score_inc) cnt++; end
        checks++;
        if (cnt !== 0) begin errors++; $display("FAIL score_respawn count=%0d want 0", cnt); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] hist;
        bus.pipe1_x = 11'd101;
        bus.pipe2_x = 11'd103;
        frame();
        repeat (2) tick();
        bus.pipe1_x = 11'd100;
        bus.pipe2_x = 11'd98;
        frame();
        for (int i = 0; i < 5; i++) begin tick(); hist[i] = bus.score_inc; end
        checks++;
        if (hist !== 5'b00011) begin errors++; $display("FAIL double_pass history=%b want 00011", hist); end
    endtask

    task automatic test_collision();
        int cnt = 0, first = 0;
        bus.pipe1_x = 11'd101;
        frame();
        repeat (2) tick();
        bus.pipe1_x = 11'd90;
        bus.collision = 1'b1;
        frame();
        bus.collision = 1'b0;
        tick();
        checks++;
        if ({bus.state, bus.run_en, bus.fall_en, bus.gameover} !== {3'd3, 3'b011}) begin
            errors++; $display("FAIL collide state=%0d run=%b fall=%b go=%b want 3/0/1/1", bus.state, bus.run_en, bus.fall_en, bus.gameover);
        end
        if (bus.score_inc) cnt++;
        for (int i = 0; i < 3; i++) begin tick(); if (bus.score_inc) cnt++; end
        checks++;
        if (cnt !== 0) begin errors++; $display("FAIL collide_priority score_inc count=%0d want 0", cnt); end
        bus.key_n = 1'b0;
        repeat (59) frame();
        tick();
        checks++;
        if (bus.state !== 3'd3) begin errors++; $display("FAIL dying_59 state=%0d want 3", bus.state); end
        frame();
        tick();
        checks++;
        if (bus.state !== 3'd4 || bus.gameover !== 1'b1) begin errors++; $display("FAIL over_entry state=%0d go=%b want 4/1", bus.state, bus.gameover); end
        cnt = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (bus.restart) cnt++; end
        checks++;
        if (cnt !== 0 || bus.state !== 3'd4) begin errors++; $display("FAIL over_held_key restarts=%0d state=%0d want 0/4", cnt, bus.state); end
        bus.key_n = 1'b1;
        repeat (4) tick();
        cnt = 0;
        bus.key_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.restart) begin cnt++; if (first == 0) first = i; end
        end
        bus.key_n = 1'b1;
        checks++;
        if (first !== 4 || cnt !== 1 || bus.state !== 3'd1) begin
            errors++; $display("FAIL over_restart first=%0d count=%0d state=%0d want 4/1/1", first, cnt, bus.state);
        end
    endtask

    task automatic test_reset_mid_play();
        int cnt = 0;
        bus.pipe1_x = 11'd500;
        bus.pipe2_x = 11'd800;
        repeat (30) frame();
        tick();
        checks++;
        if (bus.state !== 3'd2) begin errors++; $display("FAIL replay_state got %0d want 2", bus.state); end
        bus.pipe1_x = 11'd101;
        bus.pipe2_x = 11'd103;
        frame();
        repeat (2) tick();
        bus.pipe1_x = 11'd100;
        bus.pipe2_x = 11'd98;
        frame();
        tick();
        checks++;
        if (bus.score_inc !== 1'b1) begin errors++; $display("FAIL pending_setup score_inc=%b want 1", bus.score_inc); end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.score_inc !== 1'b0) begin errors++; $display("FAIL async_reset state=%0d score_inc=%b want 0/0", bus.state, bus.score_inc); end
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); if (bus.score_inc || bus.restart) cnt++; end
        checks++;
        if (cnt !== 0 || bus.state !== 3'd0) begin errors++; $display("FAIL post_reset pulses=%0d state=%0d want 0/0", cnt, bus.state); end
    endtask

    initial begin
        bus.key_n      = 1'b1;
        bus.frame_tick = 1'b0;
        bus.collision  = 1'b0;
        bus.bird_x     = 11'd100;
        bus.pipe1_x    = 11'd500;
        bus.pipe2_x    = 11'd800;
        test_reset();
        test_start();
        test_flap();
        test_score();
        test_back_to_back();
        test_collision();
        test_reset_mid_play();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
